// File: rtl/display_pkg.sv
// display_pkg: shared segment patterns, blank constants and digit indices for the display scanner.
package display_pkg;
   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam logic [1:0] IDX_SEC0 = 2'd0;
   localparam logic [1:0] IDX_SEC1 = 2'd1;
   localparam logic [1:0] IDX_MIN0 = 2'd2;
   localparam logic [1:0] IDX_MIN1 = 2'd3;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low 7-segment pattern, dark for values above 9.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [7:0] seg_o
);
   always_comb begin
      seg_o = SEG_OFF;
      case (digit_i)
         4'd0: seg_o = SEG_0;
         4'd1: seg_o = SEG_1;
         4'd2: seg_o = SEG_2;
         4'd3: seg_o = SEG_3;
         4'd4: seg_o = SEG_4;
         4'd5: seg_o = SEG_5;
         4'd6: seg_o = SEG_6;
         4'd7: seg_o = SEG_7;
         4'd8: seg_o = SEG_8;
         4'd9: seg_o = SEG_9;
         default: seg_o = SEG_OFF;
      endcase
   end
endmodule

// File: rtl/display_scanner.sv
// display_scanner: snapshots MM:SS once per frame and multiplexes it onto a 4-digit common-anode display.
// Define DISPLAY_SCANNER_COLON_EN to light the DP of minute0 as the MM.SS separator.
module display_scanner
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_DIV    = 25000000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       in_clock,
   input  logic       in_reset,
   input  logic [3:0] in_minute1,
   input  logic [3:0] in_minute0,
   input  logic [3:0] in_second1,
   input  logic [3:0] in_second0,
   input  logic       in_adjust,
   input  logic       in_select,
   output logic [7:0] out_seg,
   output logic [3:0] out_an,
   output logic       out_frame_start
);
   localparam int PW  = $clog2(REFRESH_DIV);
   localparam int BW  = $clog2(BLINK_DIV);
   localparam int BKW = $clog2(BLANK_CYCLES + 2);

   logic [PW-1:0]  presc_q, presc_d;
   logic [1:0]     idx_q, idx_d;
   logic [BKW-1:0] blank_q, blank_d;
   logic [BW-1:0]  blink_q, blink_d;
   logic           phase_q, phase_d;
   logic [15:0]    snap_q, snap_d;
   logic           frame_q, frame_d;
   logic [7:0]     seg_q, seg_d;
   logic [3:0]     an_q, an_d;
   logic           tick, bwrap, off;
   logic [3:0]     digit;
   logic [7:0]     pat;

   seg7_decode u_dec (.digit_i(digit), .seg_o(pat));

   always_comb begin
      tick    = presc_q == PW'(REFRESH_DIV - 1);
      bwrap   = blink_q == BW'(BLINK_DIV - 1);
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = tick ? idx_q + 2'd1 : idx_q;
      blank_d = tick ? BKW'(BLANK_CYCLES) : (blank_q != '0 ? blank_q - 1'b1 : blank_q);
      frame_d = tick && idx_q == IDX_MIN1;
      snap_d  = frame_d ? {in_minute1, in_minute0, in_second1, in_second0} : snap_q;
      blink_d = (!in_adjust || bwrap) ? '0 : blink_q + 1'b1;
      phase_d = in_adjust && (phase_q ^ bwrap);
      digit   = snap_q[{idx_q, 2'b00} +: 4];
      // select=1 blanks indices 0,1 (idx[1]=0); select=0 blanks 2,3
      off     = blank_q != '0 || (phase_q && idx_q[1] != in_select);
      an_d    = off ? AN_OFF : ~(4'b0001 << idx_q);
`ifdef DISPLAY_SCANNER_COLON_EN
      seg_d   = off ? SEG_OFF : (idx_q == IDX_MIN0 ? {1'b0, pat[6:0]} : pat);
`else
      seg_d   = off ? SEG_OFF : pat;
`endif
   end

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         presc_q <= '0;
         idx_q   <= IDX_SEC0;
         blank_q <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
         snap_q  <= '0;
         frame_q <= 1'b0;
         seg_q   <= SEG_OFF;
         an_q    <= AN_OFF;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         blank_q <= blank_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         snap_q  <= snap_d;
         frame_q <= frame_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign out_seg         = seg_q;
   assign out_an          = an_q;
   assign out_frame_start = frame_q;
endmodule
